// File: rtl/roic_line_deinterleave.sv
// roic_line_deinterleave
// Converts the group-interleaved pixel stream (0,64,128,192,1,65,...) from the
// reorder stage back into linear pixel order. Two line banks ping-pong: one
// line is written while the other is streamed out over valid/ready.
// Optional build macro: ROIC_DEINT_TESTPAT_EN adds a test_pat input that
// replaces RAM data with {bank, zeros, address} for a whole line.
module roic_line_deinterleave #(
    parameter int DATA_W         = 24,
    parameter int PATTERN_STEP   = 64,
    parameter int PATTERN_GROUPS = 4,
    parameter int LINE_LEN       = PATTERN_STEP * PATTERN_GROUPS,
    parameter int ADDR_W         = $clog2(LINE_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [DATA_W-1:0] indata,
`ifdef ROIC_DEINT_TESTPAT_EN
    input  logic              test_pat,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] outdata,
    output logic              out_last,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_t;

    // Both banks share one array; the bank number is the top address bit.
    logic [DATA_W-1:0] r_mem [0:2*LINE_LEN-1];

    logic [ADDR_W-1:0] r_wr_cnt;
    logic              r_wr_bank;
    logic [1:0]        r_full;
    logic              r_overflow;

    rd_state_t         r_state;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_out_valid;
    logic              r_out_last;
    logic [DATA_W-1:0] r_outdata;

    logic              w_wr_fire;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_other_bank;
    logic              w_fetch;
    logic              w_fetch_bank;
    logic [ADDR_W-1:0] w_fetch_addr;
    logic              w_rd_done;
    logic [DATA_W-1:0] w_fetch_data;

    // A word is written only into a bank that is not holding a complete line.
    assign w_wr_fire    = in_en && !r_full[r_wr_bank];
    // Sample k belongs to group k%GROUPS, position k/GROUPS within that group.
    assign w_wr_addr    = ADDR_W'((int'(r_wr_cnt) % PATTERN_GROUPS) * PATTERN_STEP
                                  + int'(r_wr_cnt) / PATTERN_GROUPS);
    assign w_other_bank = ~r_rd_bank;

    // Decide whether a RAM word is fetched into the output register this cycle.
    always_comb begin
        w_fetch      = 1'b0;
        w_fetch_bank = r_rd_bank;
        w_fetch_addr = r_rd_addr;
        w_rd_done    = 1'b0;
        case (r_state)
            RD_PRIME: begin
                w_fetch      = 1'b1;
                w_fetch_addr = '0;
            end
            RD_STREAM: begin
                if (out_ready) begin
                    if (r_out_last) begin
                        w_rd_done = 1'b1;
                        // Next line already waiting: start it without a bubble.
                        if (r_full[w_other_bank]) begin
                            w_fetch      = 1'b1;
                            w_fetch_bank = w_other_bank;
                            w_fetch_addr = '0;
                        end
                    end else begin
                        w_fetch = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef ROIC_DEINT_TESTPAT_EN
    logic r_tp;
    logic w_new_line;
    logic w_fetch_tp;

    // test_pat is latched when a line starts and held until the next one.
    assign w_new_line   = (r_state == RD_PRIME) || (w_rd_done && w_fetch);
    assign w_fetch_tp   = w_new_line ? test_pat : r_tp;
    assign w_fetch_data = w_fetch_tp
                        ? {w_fetch_bank, {(DATA_W-1-ADDR_W){1'b0}}, w_fetch_addr}
                        : r_mem[{w_fetch_bank, w_fetch_addr}];

    // Hold the test-pattern select for the duration of a line.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tp <= 1'b0;
        end else if (w_new_line) begin
            r_tp <= test_pat;
        end
    end
`else
    assign w_fetch_data = r_mem[{w_fetch_bank, w_fetch_addr}];
`endif

    // Line buffer RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= indata;
        end
    end

    // Write counter, bank-full flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            if (in_en && r_full[r_wr_bank]) begin
                r_overflow <= 1'b1;
            end
            // Read releases one bank while the write may fill the other one.
            if (w_rd_done) begin
                r_full[r_rd_bank] <= 1'b0;
            end
            if (w_wr_fire) begin
                if (r_wr_cnt == ADDR_W'(LINE_LEN-1)) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_cnt          <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                end
            end
        end
    end

    // Read FSM with registered output word, valid and last flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RD_IDLE;
            r_rd_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_outdata   <= '0;
        end else begin
            if (w_fetch) begin
                r_outdata   <= w_fetch_data;
                r_rd_addr   <= w_fetch_addr + ADDR_W'(1);
                r_out_last  <= (w_fetch_addr == ADDR_W'(LINE_LEN-1));
                r_out_valid <= 1'b1;
            end
            if (w_rd_done) begin
                r_rd_bank <= w_other_bank;
            end
            case (r_state)
                RD_IDLE: begin
                    if (r_full[r_rd_bank]) begin
                        r_state <= RD_PRIME;
                    end
                end
                RD_PRIME: begin
                    r_state <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (w_rd_done && !w_fetch) begin
                        r_state     <= RD_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign outdata   = r_outdata;
    assign overflow  = r_overflow;
    assign busy      = r_full[0] | r_full[1] | (r_wr_cnt != '0);

endmodule
